// File: rtl/tic_toc_pkg.sv
// Shared definitions for the tic-tac-toe computer-move engine:
// cell codes, FSM states, the line scan table and the fallback preference order.
package tic_toc_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    PLYR    = 2'b01,
    COMP    = 2'b10,
    ILLEGAL = 2'b11
  } cell_e;

  typedef enum logic [2:0] {
    IDLE,
    WIN,
    BLOCK,
    FALLBACK,
    DONE
  } state_e;

  localparam int unsigned NLINES = 8;

  // Line k, slot j lives at [(3k+j)*4 +: 4]; listed high line first.
  localparam logic [NLINES*3*4-1:0] LINE_TBL = {
    4'd6, 4'd4, 4'd2,   // line 7
    4'd8, 4'd4, 4'd0,   // line 6
    4'd8, 4'd5, 4'd2,   // line 5
    4'd7, 4'd4, 4'd1,   // line 4
    4'd6, 4'd3, 4'd0,   // line 3
    4'd8, 4'd7, 4'd6,   // line 2
    4'd5, 4'd4, 4'd3,   // line 1
    4'd2, 4'd1, 4'd0    // line 0
  };

  // Preference position p lives at [p*4 +: 4]: 4, 0, 2, 6, 8, 1, 3, 5, 7.
  localparam logic [9*4-1:0] FALLBACK_ORDER = {
    4'd7, 4'd5, 4'd3, 4'd1, 4'd8, 4'd6, 4'd2, 4'd0, 4'd4
  };

  function automatic logic [3:0] line_cell(input logic [2:0] k, input int unsigned j);
    return LINE_TBL[(3 * int'(k) + j) * 4 +: 4];
  endfunction

  function automatic logic [3:0] fallback_cell(input int unsigned p);
    return FALLBACK_ORDER[p * 4 +: 4];
  endfunction

endpackage

// File: rtl/tic_toc_comp_move_if.sv
// Request/result bundle for the computer-move engine.
import tic_toc_pkg::*;

interface tic_toc_comp_move_if #(parameter int unsigned NCELL = 9);
  logic [2*NCELL-1:0] board;
  logic               req;
  logic               busy;
  logic               move_valid;
  logic [NCELL-1:0]   move;
  logic               no_space;
  logic               board_err;

  modport master (
    output board, req,
    input  busy, move_valid, move, no_space, board_err
  );

  modport slave (
    input  board, req,
    output busy, move_valid, move, no_space, board_err
  );
endinterface

// File: rtl/tic_toc_line_eval.sv
// Combinational evaluator for one 3-cell line: flags two-of-side plus one empty
// and returns the empty slot one-hot (slot order matches the cells input).
import tic_toc_pkg::*;

module tic_toc_line_eval (
  input  logic [5:0] cells,
  input  cell_e      side,
  output logic       hit,
  output logic [2:0] empty_oh
);
  logic [2:0] is_side;
  logic [2:0] is_empty;

  always_comb begin
    is_side  = '0;
    is_empty = '0;
    for (int unsigned j = 0; j < 3; j++) begin
      is_side[j]  = (cells[2*j +: 2] == side);
      is_empty[j] = (cells[2*j +: 2] == EMPTY);
    end
    hit = ((is_empty == 3'b001) && (is_side == 3'b110)) ||
          ((is_empty == 3'b010) && (is_side == 3'b101)) ||
          ((is_empty == 3'b100) && (is_side == 3'b011));
    empty_oh = hit ? is_empty : '0;
  end
endmodule

// File: rtl/tic_toc_comp_move.sv
// Computer-move engine: captures a board snapshot, scans lines for a winning
// move, then a blocking move, then falls back to a fixed preference order.
import tic_toc_pkg::*;

module tic_toc_comp_move #(
  parameter int unsigned NCELL = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*NCELL-1:0] board,
  input  logic               req,
  output logic               busy,
  output logic               move_valid,
  output logic [NCELL-1:0]   move,
  output logic               no_space,
  output logic               board_err
);
  state_e             state_q, state_d;
  logic [2*NCELL-1:0] snap_q, snap_d;
  logic [2:0]         line_q, line_d;
  logic               busy_q, busy_d;
  logic               move_valid_q, move_valid_d;
  logic [NCELL-1:0]   move_q, move_d;
  logic               no_space_q, no_space_d;
  logic               board_err_q, board_err_d;

  logic [5:0]         line_cells;
  cell_e              side;
  logic               line_hit;
  logic [2:0]         line_empty;
  logic [NCELL-1:0]   hit_move;
  logic [NCELL-1:0]   fb_move;
  logic               fb_found;
  logic               cap_full;
  logic               cap_err;

  always_comb begin
    line_cells = '0;
    side       = (state_q == BLOCK) ? PLYR : COMP;
    for (int unsigned j = 0; j < 3; j++)
      line_cells[2*j +: 2] = snap_q[2*line_cell(line_q, j) +: 2];
  end

  tic_toc_line_eval u_line_eval (
    .cells    (line_cells),
    .side     (side),
    .hit      (line_hit),
    .empty_oh (line_empty)
  );

  always_comb begin
    hit_move = '0;
    for (int unsigned j = 0; j < 3; j++)
      if (line_empty[j]) hit_move[line_cell(line_q, j)] = 1'b1;
  end

  always_comb begin
    fb_move  = '0;
    fb_found = 1'b0;
    for (int unsigned p = 0; p < NCELL; p++) begin
      if (!fb_found && (snap_q[2*fallback_cell(p) +: 2] == EMPTY)) begin
        fb_move[fallback_cell(p)] = 1'b1;
        fb_found                  = 1'b1;
      end
    end
  end

  // Full/illegal flags are taken from the live board so they land with the snapshot.
  always_comb begin
    cap_full = 1'b1;
    cap_err  = 1'b0;
    for (int unsigned i = 0; i < NCELL; i++) begin
      if (board[2*i +: 2] == EMPTY)   cap_full = 1'b0;
      if (board[2*i +: 2] == ILLEGAL) cap_err  = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    line_d       = line_q;
    busy_d       = busy_q;
    move_valid_d = 1'b0;
    move_d       = move_q;
    no_space_d   = no_space_q;
    board_err_d  = board_err_q;
    unique case (state_q)
      IDLE: begin
        // busy is still high in the move_valid cycle; it drops here and blocks capture.
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (req) begin
          snap_d      = board;
          busy_d      = 1'b1;
          move_d      = '0;
          no_space_d  = cap_full;
          board_err_d = cap_err;
          line_d      = '0;
          state_d     = cap_full ? DONE : WIN;
        end
      end
      WIN, BLOCK: begin
        if (line_hit) begin
          move_d  = hit_move;
          state_d = DONE;
        end else if (line_q == 3'(NLINES - 1)) begin
          line_d  = '0;
          state_d = (state_q == WIN) ? BLOCK : FALLBACK;
        end else begin
          line_d = line_q + 3'd1;
        end
      end
      FALLBACK: begin
        move_d  = fb_move;
        state_d = DONE;
      end
      DONE: begin
        move_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      line_q       <= '0;
      busy_q       <= 1'b0;
      move_valid_q <= 1'b0;
      move_q       <= '0;
      no_space_q   <= 1'b0;
      board_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      line_q       <= line_d;
      busy_q       <= busy_d;
      move_valid_q <= move_valid_d;
      move_q       <= move_d;
      no_space_q   <= no_space_d;
      board_err_q  <= board_err_d;
    end
  end

  assign busy       = busy_q;
  assign move_valid = move_valid_q;
  assign move       = move_q;
  assign no_space   = no_space_q;
  assign board_err  = board_err_q;
endmodule
